// File: rtl/sys_description_reader.sv
// Avalon-MM read master: fetches the header at ROM word 0, then streams entries 1..N on ready/valid.
// Optional checksum of the entries against header[63:48] when SYS_DESC_READER_CHECKSUM_EN is defined.
module sys_description_reader #(
  parameter int          ADDR_W       = 9,
  parameter int          DATA_W       = 64,
  parameter int          READ_LATENCY = 2,
  parameter int          BUF_DEPTH    = 4,
  parameter logic [31:0] MAGIC        = 32'h5359_5344
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] rom_address,
  output logic              rom_chipselect,
  output logic              rom_read,
  output logic [7:0]        rom_byteenable,
  output logic              rom_clken,
  input  logic [DATA_W-1:0] rom_readdata,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [ADDR_W-1:0] out_index
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int MAX_N = (2 ** ADDR_W) - 1;

  typedef enum logic [2:0] {S_IDLE, S_HDR_REQ, S_HDR_WAIT, S_STREAM, S_FIN} state_t;

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d, done_q, done_d, error_q, error_d, rd_q, rd_d;
  logic [ADDR_W-1:0]       addr_q, addr_d, n_q, n_d, issued_q, issued_d, popped_q, popped_d;
  logic [CNT_W-1:0]        credit_q, credit_d, fill_q, fill_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [READ_LATENCY-1:0] rvld_q, rvld_d;
  logic [DATA_W-1:0]       mem_q [BUF_DEPTH];
`ifdef SYS_DESC_READER_CHECKSUM_EN
  logic [ADDR_W-1:0]       recv_q, recv_d;
  logic [15:0]             csum_q, csum_d, acc_q, acc_d, acc_nxt;
`endif

  logic        ret_valid, push, pop, last_pop, issue;
  logic [15:0] hdr_n;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A returned word is only trusted if this block issued the strobe READ_LATENCY cycles ago.
  assign ret_valid = rvld_q[READ_LATENCY-1];
  assign hdr_n     = rom_readdata[47:32];
  assign out_valid = (fill_q != '0);
  assign push      = (state_q == S_STREAM) && ret_valid;
  assign pop       = out_valid && out_ready;
  assign last_pop  = pop && (popped_q + ADDR_W'(1) == n_q);
  // Credits cover decided, in-flight and buffered reads, so the FIFO can never overflow.
  assign issue     = (state_q == S_STREAM) && (issued_q < n_q) &&
                     ((credit_q - CNT_W'(pop)) < CNT_W'(BUF_DEPTH));
`ifdef SYS_DESC_READER_CHECKSUM_EN
  assign acc_nxt   = acc_q ^ rom_readdata[15:0] ^ rom_readdata[31:16] ^
                     rom_readdata[47:32] ^ rom_readdata[63:48];
`endif

  // NOTE: every signal gets a default at the top of always_comb so no path leaves it unassigned (no latches).
  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    error_d  = error_q;
    rd_d     = 1'b0;
    addr_d   = addr_q;
    n_d      = n_q;
    issued_d = issued_q;
    popped_d = popped_q;
    credit_d = credit_q + CNT_W'(issue) - CNT_W'(pop);
    rvld_d   = (rvld_q << 1) | READ_LATENCY'(rd_q);
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q + CNT_W'(push) - CNT_W'(pop);
`ifdef SYS_DESC_READER_CHECKSUM_EN
    recv_d   = recv_q;
    csum_d   = csum_q;
    acc_d    = acc_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_HDR_REQ;
          busy_d   = 1'b1;
          error_d  = 1'b0;
          rd_d     = 1'b1;
          addr_d   = '0;
          n_d      = '0;
          issued_d = '0;
          popped_d = '0;
          credit_d = '0;
`ifdef SYS_DESC_READER_CHECKSUM_EN
          recv_d   = '0;
          acc_d    = '0;
`endif
        end
      end
      S_HDR_REQ: state_d = S_HDR_WAIT;
      S_HDR_WAIT: begin
        if (ret_valid) begin
          if ((rom_readdata[31:0] != MAGIC) || (int'(hdr_n) > MAX_N)) begin
            error_d = 1'b1;
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else if (hdr_n == 16'd0) begin
            state_d = S_FIN;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_STREAM;
            n_d     = hdr_n[ADDR_W-1:0];
`ifdef SYS_DESC_READER_CHECKSUM_EN
            csum_d  = rom_readdata[63:48];
`endif
          end
        end
      end
      S_STREAM: begin
        if (issue) begin
          rd_d     = 1'b1;
          addr_d   = issued_q + ADDR_W'(1);
          issued_d = issued_q + ADDR_W'(1);
        end
`ifdef SYS_DESC_READER_CHECKSUM_EN
        // Final word lands at least one cycle before its beat can pop, so error precedes done.
        if (push) begin
          recv_d = recv_q + ADDR_W'(1);
          acc_d  = acc_nxt;
          if ((recv_q + ADDR_W'(1) == n_q) && (acc_nxt != csum_q)) error_d = 1'b1;
        end
`endif
        if (pop) popped_d = popped_q + ADDR_W'(1);
        if (last_pop) begin
          state_d = S_FIN;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      rd_q     <= 1'b0;
      addr_q   <= '0;
      n_q      <= '0;
      issued_q <= '0;
      popped_q <= '0;
      credit_q <= '0;
      rvld_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
`ifdef SYS_DESC_READER_CHECKSUM_EN
      recv_q   <= '0;
      csum_q   <= '0;
      acc_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      error_q  <= error_d;
      rd_q     <= rd_d;
      addr_q   <= addr_d;
      n_q      <= n_d;
      issued_q <= issued_d;
      popped_q <= popped_d;
      credit_q <= credit_d;
      rvld_q   <= rvld_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
`ifdef SYS_DESC_READER_CHECKSUM_EN
      recv_q   <= recv_d;
      csum_q   <= csum_d;
      acc_q    <= acc_d;
`endif
    end
  end

  // NOTE: FIFO storage is deliberately not reset; fill_q gates every read of it, including out_data.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= rom_readdata;
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;
  assign rom_read       = rd_q;
  assign rom_chipselect = rd_q;
  assign rom_address    = addr_q;
  assign rom_byteenable = 8'hFF;
  assign rom_clken      = 1'b1;
  assign out_data       = out_valid ? mem_q[rd_ptr_q] : '0;
  assign out_index      = out_valid ? popped_q + ADDR_W'(1) : '0;
  assign out_last       = out_valid && (popped_q + ADDR_W'(1) == n_q);

endmodule
